// File: rtl/column_drop_tracker.sv
// Connect-four board occupancy owner. Each column is a 6-bit thermometer
// filled from bit 0. A drop request is checked against the board, and the
// accepted piece falls one row per step_tick from the top row to its landing
// row. The column is updated on the tick that lands the piece, and a one-cycle
// done pulse reports the result.
module column_drop_tracker #(
    parameter int COLS = 7,
    parameter int ROWS = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 drop_valid,
    output logic                 drop_ready,
    input  logic [2:0]           drop_col,
    input  logic                 step_tick,
    output logic [COLS*ROWS-1:0] col_state,
    output logic                 anim_active,
    output logic [2:0]           anim_col,
    output logic [2:0]           anim_row,
    output logic                 done_valid,
    output logic [2:0]           done_row,
    output logic [ROWS-1:0]      done_onoff,
    output logic                 reject,
    output logic                 board_full
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [ROWS-1:0] cols_q [COLS];
    logic [ROWS-1:0] cols_d [COLS];
    logic [2:0]      col_q, col_d;      // column of the piece in flight
    logic [2:0]      t_q, t_d;          // landing row code
    logic [2:0]      row_q, row_d;      // current animation row code
    logic            reject_q, reject_d;
    logic            live_q;            // low until the first edge after reset release

    logic            col_in_range;
    logic [ROWS-1:0] sel_thermo;
    logic            accept;

    // Stored thermometers are contiguous from bit 0, so the count of ones is the fill height.
    function automatic logic [2:0] popcount(input logic [ROWS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < ROWS; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

    // Thermometer of the requested column; out-of-range columns read as empty.
    always_comb begin
        col_in_range = int'(drop_col) < COLS;
        sel_thermo   = '0;
        if (col_in_range) begin
            sel_thermo = cols_q[drop_col];
        end
    end

    assign drop_ready = live_q & (state_q == IDLE) & ~clear;
    assign accept     = drop_valid & drop_ready;

    // Next-state and next-board logic; clear outranks everything else.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cols_d   = cols_q;
        col_d    = col_q;
        t_d      = t_q;
        row_d    = row_q;
        reject_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            for (int c = 0; c < COLS; c++) begin
                cols_d[c] = '0;
            end
            col_d = '0;
            t_d   = '0;
            row_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!col_in_range || sel_thermo[ROWS-1]) begin
                            reject_d = 1'b1;
                        end else begin
                            col_d   = drop_col;
                            t_d     = popcount(sel_thermo);
                            row_d   = 3'(ROWS - 1);
                            state_d = FALL;
                        end
                    end
                end
                FALL: begin
                    if (step_tick) begin
                        if (row_q == t_q) begin
                            state_d        = COMMIT;
                            cols_d[col_q]  = {cols_q[col_q][ROWS-2:0], 1'b1};
                        end else begin
                            row_d = row_q - 3'd1;
                        end
                    end
                end
                COMMIT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, board and flight registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            // NOTE: the board storage is reset because an empty board is the defined power-up state.
            for (int c = 0; c < COLS; c++) begin
                cols_q[c] <= '0;
            end
            col_q    <= '0;
            t_q      <= '0;
            row_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= state_d;
            cols_q   <= cols_d;
            col_q    <= col_d;
            t_q      <= t_d;
            row_q    <= row_d;
            reject_q <= reject_d;
        end
    end

    // Holds drop_ready low while in reset and until the first edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Output decode; flight and done fields read zero outside their phases.
    always_comb begin
        col_state   = '0;
        board_full  = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            col_state[c*ROWS +: ROWS] = cols_q[c];
            board_full                = board_full & cols_q[c][ROWS-1];
        end
        anim_active = (state_q == FALL);
        anim_col    = anim_active ? col_q : 3'd0;
        anim_row    = anim_active ? row_q : 3'd0;
        done_valid  = (state_q == COMMIT);
        done_row    = done_valid ? t_q : 3'd0;
        done_onoff  = done_valid ? cols_q[col_q] : '0;
        reject      = reject_q;
    end

endmodule
